// File: rtl/fault_aware_weight_allocator.sv
// fault_aware_weight_allocator
//   Places logical weight rows onto physical systolic rows before each pass.
//   On start it loads the fault list into the faulty-PE storage, then for
//   every weight row fetches its zero-weight flags, asks storage for a faulty
//   row that can absorb the weight, and otherwise uses the lowest free
//   healthy row. Each placement is written to the mapping table.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   start, num_weight_rows     allocation request and weight-row count
//   busy, done                 in-progress flag, one-cycle completion pulse
//   alloc_error                overflow / protocol error, held until next start
//   faults_uncovered           unused fault entries remained at completion
//   st_*                       faulty-PE storage load/query interface
//   wt_rd_*                    weight zero-flag buffer read port
//   map_*                      mapping-table write port
module fault_aware_weight_allocator #(
    parameter int SYSTOLIC_SIZE = 8,
    parameter int ADDR_WIDTH    = $clog2(SYSTOLIC_SIZE),
    parameter int CNT_WIDTH     = $clog2(SYSTOLIC_SIZE + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [CNT_WIDTH-1:0]     num_weight_rows,
    output logic                     busy,
    output logic                     done,
    output logic                     alloc_error,
    output logic                     faults_uncovered,
    output logic                     st_wr_en,
    output logic                     st_weight_valid,
    output logic [SYSTOLIC_SIZE-1:0] st_zero_weight_flags,
    output logic [ADDR_WIDTH-1:0]    st_current_row_addr,
    input  logic                     st_match_success,
    input  logic                     st_match_failed,
    input  logic [ADDR_WIDTH-1:0]    st_faulty_row_addr,
    input  logic [SYSTOLIC_SIZE-1:0] st_faulty_rows_mask,
    input  logic                     st_all_faulty_matched,
    output logic                     wt_rd_en,
    output logic [ADDR_WIDTH-1:0]    wt_rd_addr,
    input  logic [SYSTOLIC_SIZE-1:0] wt_rd_data,
    output logic                     map_wr_en,
    output logic [ADDR_WIDTH-1:0]    map_weight_idx,
    output logic [ADDR_WIDTH-1:0]    map_phys_row,
    output logic                     map_is_faulty_row
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_LOADWAIT, S_FETCH, S_QUERY, S_WAIT, S_RESULT, S_DONE
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LP_MAX_ROWS = CNT_WIDTH'(SYSTOLIC_SIZE);

    state_t                   r_state, w_next_state;
    logic [CNT_WIDTH-1:0]     r_count;
    logic [ADDR_WIDTH-1:0]    r_idx;
    logic [SYSTOLIC_SIZE-1:0] r_used;
    logic                     r_fallback;
    logic                     r_alloc_error;
    logic                     r_faults_uncovered;
    logic                     r_map_wr_en;
    logic [ADDR_WIDTH-1:0]    r_map_weight_idx;
    logic [ADDR_WIDTH-1:0]    r_map_phys_row;
    logic                     r_map_is_faulty_row;

    logic                     w_free_found;
    logic [ADDR_WIDTH-1:0]    w_free_row;
    logic                     w_place;
    logic                     w_place_faulty;
    logic [ADDR_WIDTH-1:0]    w_place_row;
    logic                     w_set_error;
    logic                     w_last;

    // Lowest-indexed row that is neither faulty nor already occupied.
    always_comb begin
        w_free_found = 1'b0;
        w_free_row   = '0;
        for (int unsigned r = 0; r < SYSTOLIC_SIZE; r++) begin
            if (!w_free_found && !st_faulty_rows_mask[r] && !r_used[r]) begin
                w_free_found = 1'b1;
                w_free_row   = ADDR_WIDTH'(r);
            end
        end
    end

    assign w_last = (CNT_WIDTH'(r_idx) + CNT_WIDTH'(1)) == r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state    = r_state;
        st_wr_en        = 1'b0;
        st_weight_valid = 1'b0;
        wt_rd_en        = 1'b0;
        w_place         = 1'b0;
        w_place_faulty  = 1'b0;
        w_place_row     = '0;
        w_set_error     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (num_weight_rows > LP_MAX_ROWS) begin
                        w_set_error  = 1'b1;
                        w_next_state = S_DONE;
                    end else begin
                        w_next_state = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                st_wr_en     = 1'b1;
                w_next_state = S_LOADWAIT;
            end
            S_LOADWAIT: w_next_state = (r_count == '0) ? S_DONE : S_FETCH;
            S_FETCH: begin
                // Once every fault entry is consumed no query can succeed,
                // so the flag read and storage round-trip are skipped.
                if (st_all_faulty_matched) begin
                    w_next_state = S_RESULT;
                end else begin
                    wt_rd_en     = 1'b1;
                    w_next_state = S_QUERY;
                end
            end
            S_QUERY: begin
                st_weight_valid = 1'b1;
                w_next_state    = S_WAIT;
            end
            S_WAIT: w_next_state = S_RESULT;
            S_RESULT: begin
                if (!r_fallback && st_match_success) begin
                    w_place        = 1'b1;
                    w_place_faulty = 1'b1;
                    w_place_row    = st_faulty_row_addr;
                end else if (r_fallback || st_match_failed) begin
                    if (w_free_found) begin
                        w_place     = 1'b1;
                        w_place_row = w_free_row;
                    end else begin
                        w_set_error = 1'b1;
                    end
                end else begin
                    // Storage answered neither success nor failure.
                    w_set_error = 1'b1;
                end
                w_next_state = (w_set_error || w_last) ? S_DONE : S_FETCH;
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count             <= '0;
            r_idx               <= '0;
            r_used              <= '0;
            r_fallback          <= 1'b0;
            r_alloc_error       <= 1'b0;
            r_faults_uncovered  <= 1'b0;
            r_map_wr_en         <= 1'b0;
            r_map_weight_idx    <= '0;
            r_map_phys_row      <= '0;
            r_map_is_faulty_row <= 1'b0;
        end else begin
            r_map_wr_en <= 1'b0;
            if (w_set_error) r_alloc_error <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (start && !w_set_error) begin
                        r_count            <= num_weight_rows;
                        r_alloc_error      <= 1'b0;
                        r_faults_uncovered <= 1'b0;
                        r_used             <= '0;
                        r_idx              <= '0;
                    end
                end
                S_LOADWAIT: r_idx <= '0;
                S_FETCH:    r_fallback <= st_all_faulty_matched;
                S_RESULT: begin
                    if (w_place) begin
                        r_used[w_place_row] <= 1'b1;
                        r_map_wr_en         <= 1'b1;
                        r_map_weight_idx    <= r_idx;
                        r_map_phys_row      <= w_place_row;
                        r_map_is_faulty_row <= w_place_faulty;
                    end
                    if (w_next_state == S_FETCH) r_idx <= r_idx + 1'b1;
                end
                S_DONE: r_faults_uncovered <= ~st_all_faulty_matched;
                default: ;
            endcase
        end
    end

    assign busy                 = (r_state != S_IDLE);
    assign done                 = (r_state == S_DONE);
    assign alloc_error          = r_alloc_error;
    assign faults_uncovered     = r_faults_uncovered;
    assign st_zero_weight_flags = st_weight_valid ? wt_rd_data : '0;
    assign st_current_row_addr  = st_weight_valid ? r_idx : '0;
    assign wt_rd_addr           = wt_rd_en ? r_idx : '0;
    assign map_wr_en            = r_map_wr_en;
    assign map_weight_idx       = r_map_weight_idx;
    assign map_phys_row         = r_map_phys_row;
    assign map_is_faulty_row    = r_map_is_faulty_row;

endmodule

// File: tb/tb_fault_aware_weight_allocator.sv
// Bench for fault_aware_weight_allocator: behavioural faulty-PE storage and
// weight-flag buffer, a strobe monitor, a table of allocation scenarios with
// hand-computed mappings, plus timing, restart and mid-run reset sequences.
module tb_fault_aware_weight_allocator;
    localparam int N  = 8;
    localparam int AW = 3;
    localparam int CW = 4;

    logic          clk, rst_n, start;
    logic [CW-1:0] num_weight_rows;
    logic          busy, done, alloc_error, faults_uncovered;
    logic          st_wr_en, st_weight_valid;
    logic [N-1:0]  st_zero_weight_flags;
    logic [AW-1:0] st_current_row_addr;
    logic          st_match_success, st_match_failed;
    logic [AW-1:0] st_faulty_row_addr;
    logic [N-1:0]  st_faulty_rows_mask;
    logic          st_all_faulty_matched;
    logic          wt_rd_en;
    logic [AW-1:0] wt_rd_addr;
    logic [N-1:0]  wt_rd_data;
    logic          map_wr_en;
    logic [AW-1:0] map_weight_idx, map_phys_row;
    logic          map_is_faulty_row;

    fault_aware_weight_allocator #(.SYSTOLIC_SIZE(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_weight_rows(num_weight_rows),
        .busy(busy), .done(done), .alloc_error(alloc_error),
        .faults_uncovered(faults_uncovered), .st_wr_en(st_wr_en),
        .st_weight_valid(st_weight_valid), .st_zero_weight_flags(st_zero_weight_flags),
        .st_current_row_addr(st_current_row_addr), .st_match_success(st_match_success),
        .st_match_failed(st_match_failed), .st_faulty_row_addr(st_faulty_row_addr),
        .st_faulty_rows_mask(st_faulty_rows_mask),
        .st_all_faulty_matched(st_all_faulty_matched), .wt_rd_en(wt_rd_en),
        .wt_rd_addr(wt_rd_addr), .wt_rd_data(wt_rd_data), .map_wr_en(map_wr_en),
        .map_weight_idx(map_weight_idx), .map_phys_row(map_phys_row),
        .map_is_faulty_row(map_is_faulty_row)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scenario configuration ----------------
    logic [N-1:0]        cfg_valid;
    logic [N-1:0][N-1:0] cfg_pat;
    logic [N-1:0][N-1:0] cfg_flags;
    logic                cfg_mute;

    // ---------------- storage and weight-buffer model ----------------
    logic [N-1:0]        sm_valid, sm_used;
    logic [N-1:0][N-1:0] sm_pat;
    logic                sm_succ, sm_fail;
    logic [AW-1:0]       sm_addr;
    logic                sm_hit;
    int unsigned         sm_hr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sm_valid <= '0; sm_used <= '0; sm_pat <= '0;
            sm_succ <= 1'b0; sm_fail <= 1'b0; sm_addr <= '0;
            wt_rd_data <= '0;
        end else begin
            if (st_wr_en) begin
                sm_valid <= cfg_valid; sm_pat <= cfg_pat; sm_used <= '0;
            end
            if (st_weight_valid) begin
                sm_hit = 1'b0;
                sm_hr  = 0;
                for (int unsigned r = 0; r < N; r++)
                    if (!sm_hit && sm_valid[r] && !sm_used[r] &&
                        ((sm_pat[r] & ~st_zero_weight_flags) == '0)) begin
                        sm_hit = 1'b1;
                        sm_hr  = r;
                    end
                sm_succ <= sm_hit;
                sm_fail <= !sm_hit;
                if (sm_hit) begin
                    sm_addr        <= AW'(sm_hr);
                    sm_used[sm_hr] <= 1'b1;
                end
            end
            if (wt_rd_en) wt_rd_data <= cfg_flags[wt_rd_addr];
        end
    end

    assign st_match_success      = sm_succ & ~cfg_mute;
    assign st_match_failed       = sm_fail & ~cfg_mute;
    assign st_faulty_row_addr    = sm_addr;
    assign st_faulty_rows_mask   = sm_valid;
    assign st_all_faulty_matched = ((sm_valid & ~sm_used) == '0);

    // ---------------- monitor ----------------
    int unsigned   cyc, n_st_wr, n_st_q, n_wt_rd, n_map, n_done, n_viol;
    int unsigned   done_cyc, wr_cyc;
    logic [AW-1:0] rec_idx  [1024];
    logic [AW-1:0] rec_phys [1024];
    logic          rec_f    [1024];
    int unsigned   rec_cyc  [1024];
    logic          p_wr, p_q, p_rd, p_map;

    initial begin
        cyc = 0; n_st_wr = 0; n_st_q = 0; n_wt_rd = 0; n_map = 0; n_done = 0;
        n_viol = 0; done_cyc = 0; wr_cyc = 0;
        p_wr = 1'b0; p_q = 1'b0; p_rd = 1'b0; p_map = 1'b0;
    end

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (st_wr_en) begin n_st_wr++; wr_cyc = cyc; end
            if (st_weight_valid) n_st_q++;
            if (wt_rd_en) n_wt_rd++;
            if (done) begin n_done++; done_cyc = cyc; end
            if (map_wr_en) begin
                if (n_map < 1024) begin
                    rec_idx[n_map] = map_weight_idx; rec_phys[n_map] = map_phys_row;
                    rec_f[n_map] = map_is_faulty_row; rec_cyc[n_map] = cyc;
                end
                n_map++;
            end
            if ((st_wr_en && st_weight_valid) || (st_wr_en && wt_rd_en) ||
                (st_weight_valid && wt_rd_en) || (map_wr_en && (st_wr_en || st_weight_valid)))
                n_viol++;
            if ((st_wr_en && p_wr) || (st_weight_valid && p_q) ||
                (wt_rd_en && p_rd) || (map_wr_en && p_map))
                n_viol++;
            p_wr = st_wr_en; p_q = st_weight_valid; p_rd = wt_rd_en; p_map = map_wr_en;
        end else begin
            p_wr = 1'b0; p_q = 1'b0; p_rd = 1'b0; p_map = 1'b0;
        end
    end

    // ---------------- checking ----------------
    int unsigned total, bad;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [28:0] all_outs();
        return {busy, done, alloc_error, faults_uncovered, st_wr_en, st_weight_valid,
                st_zero_weight_flags, st_current_row_addr, wt_rd_en, wt_rd_addr,
                map_wr_en, map_weight_idx, map_phys_row, map_is_faulty_row};
    endfunction

    typedef struct {
        logic [CW-1:0]        count;
        logic [N-1:0]         fvalid;
        logic [N-1:0][N-1:0]  fpat;
        logic [N-1:0][N-1:0]  flags;
        logic                 mute;
        int unsigned          exp_maps, exp_wtrd, exp_stwr;
        logic [N-1:0][AW-1:0] exp_phys;
        logic [N-1:0]         exp_f;
        logic                 exp_err, exp_unc;
    } vec_t;

    localparam int NV = 8;
    vec_t        vt [NV];
    int unsigned last_m0;

    function automatic vec_t blank(input logic [CW-1:0] count);
        vec_t v;
        v.count = count; v.fvalid = '0; v.fpat = '0; v.flags = '0; v.mute = 1'b0;
        v.exp_maps = 0; v.exp_wtrd = 0; v.exp_stwr = 1; v.exp_phys = '0;
        v.exp_f = '0; v.exp_err = 1'b0; v.exp_unc = 1'b0;
        return v;
    endfunction

    task automatic run_vec(input int i, input bit repulse);
        int unsigned d0, w0, r0, m0, v0;
        vec_t v;
        v = vt[i];
        cfg_valid = v.fvalid; cfg_pat = v.fpat; cfg_flags = v.flags; cfg_mute = v.mute;
        d0 = n_done; w0 = n_st_wr; r0 = n_wt_rd; m0 = n_map; v0 = n_viol;
        last_m0 = m0;
        @(posedge clk); #2;
        start = 1'b1; num_weight_rows = v.count;
        @(posedge clk); #2;
        start = 1'b0; num_weight_rows = '0;
        tick();
        check($sformatf("v%0d busy after start", i), 64'(busy), 64'(1));
        if (repulse) begin
            repeat (3) tick();
            start = 1'b1; num_weight_rows = 4'd3;
            tick();
            start = 1'b0; num_weight_rows = '0;
        end
        for (int k = 0; k < 300 && n_done == d0; k++) tick();
        check($sformatf("v%0d done seen", i), 64'(n_done != d0), 64'(1));
        tick(); tick();
        check($sformatf("v%0d done pulses", i), 64'(n_done - d0), 64'(1));
        check($sformatf("v%0d busy idle", i), 64'(busy), 64'(0));
        check($sformatf("v%0d st_wr_en count", i), 64'(n_st_wr - w0), 64'(v.exp_stwr));
        check($sformatf("v%0d wt_rd_en count", i), 64'(n_wt_rd - r0), 64'(v.exp_wtrd));
        check($sformatf("v%0d map count", i), 64'(n_map - m0), 64'(v.exp_maps));
        check($sformatf("v%0d alloc_error", i), 64'(alloc_error), 64'(v.exp_err));
        check($sformatf("v%0d faults_uncovered", i), 64'(faults_uncovered), 64'(v.exp_unc));
        check($sformatf("v%0d strobe rules", i), 64'(n_viol - v0), 64'(0));
        for (int unsigned k = 0; k < v.exp_maps && (m0 + k) < 1024; k++) begin
            check($sformatf("v%0d map%0d idx", i, k), 64'(rec_idx[m0+k]), 64'(k));
            check($sformatf("v%0d map%0d phys", i, k), 64'(rec_phys[m0+k]), 64'(v.exp_phys[k]));
            check($sformatf("v%0d map%0d faulty", i, k), 64'(rec_f[m0+k]), 64'(v.exp_f[k]));
        end
    endtask

    initial begin
        int unsigned q0, m0;
        total = 0; bad = 0; last_m0 = 0;
        rst_n = 1'b0; start = 1'b0; num_weight_rows = '0;
        cfg_valid = '0; cfg_pat = '0; cfg_flags = '0; cfg_mute = 1'b0;

        // v0: two matching faults, then fallback for the rest
        vt[0] = blank(4'd8);
        vt[0].fvalid = 8'b0010_0100; vt[0].fpat[2] = 8'h01; vt[0].fpat[5] = 8'h80;
        vt[0].flags[0] = 8'h01; vt[0].flags[1] = 8'h80;
        vt[0].exp_maps = 8; vt[0].exp_wtrd = 2; vt[0].exp_f = 8'b0000_0011;
        vt[0].exp_phys = {3'd7, 3'd6, 3'd4, 3'd3, 3'd1, 3'd0, 3'd5, 3'd2};
        // v1: unusable fault at row3, healthy rows run out at weight 7
        vt[1] = blank(4'd8);
        vt[1].fvalid = 8'b0000_1000; vt[1].fpat[3] = 8'h0F;
        vt[1].exp_maps = 7; vt[1].exp_wtrd = 8; vt[1].exp_err = 1'b1; vt[1].exp_unc = 1'b1;
        vt[1].exp_phys = {3'd0, 3'd7, 3'd6, 3'd5, 3'd4, 3'd2, 3'd1, 3'd0};
        // v2: single weight, fault left uncovered
        vt[2] = blank(4'd1);
        vt[2].fvalid = 8'b0000_0010; vt[2].fpat[1] = 8'h03;
        vt[2].exp_maps = 1; vt[2].exp_wtrd = 1; vt[2].exp_unc = 1'b1;
        // v3: zero weights, empty fault list
        vt[3] = blank(4'd0);
        // v4: count above array size, no load
        vt[4] = blank(4'd9);
        vt[4].exp_stwr = 0; vt[4].exp_err = 1'b1;
        // v5: storage answers neither success nor failure
        vt[5] = blank(4'd2);
        vt[5].fvalid = 8'b0000_1000; vt[5].fpat[3] = 8'h0F; vt[5].mute = 1'b1;
        vt[5].exp_wtrd = 1; vt[5].exp_err = 1'b1; vt[5].exp_unc = 1'b1;
        // v6: no faults, full array in fallback mode
        vt[6] = blank(4'd8);
        vt[6].flags = {8'h5A, 8'h11, 8'hFF, 8'h00, 8'h3C, 8'h81, 8'h0F, 8'hF0};
        vt[6].exp_maps = 8;
        vt[6].exp_phys = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
        // v7: partial-pattern match on row6, then fallback skips row6
        vt[7] = blank(4'd3);
        vt[7].fvalid = 8'b0100_0000; vt[7].fpat[6] = 8'h30; vt[7].flags[0] = 8'h3C;
        vt[7].exp_maps = 3; vt[7].exp_wtrd = 1; vt[7].exp_f = 8'b0000_0001;
        vt[7].exp_phys = {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd0, 3'd6};

        repeat (2) tick();
        check("reset outputs", 64'(all_outs()), 64'(0));
        @(posedge clk); #2 rst_n = 1'b1;
        tick();
        check("idle outputs", 64'(all_outs()), 64'(0));

        for (int i = 0; i < NV; i++) begin
            run_vec(i, 1'b0);
            if (i == 3) check("count0 done after load", 64'(done_cyc - wr_cyc), 64'(2));
        end

        // Restart pulse while busy is ignored; also check per-weight latency.
        run_vec(0, 1'b1);
        check("query latency", 64'(rec_cyc[last_m0+1] - rec_cyc[last_m0]), 64'(4));
        check("fallback latency", 64'(rec_cyc[last_m0+2] - rec_cyc[last_m0+1]), 64'(2));
        check("last map with done", 64'(done_cyc), 64'(rec_cyc[last_m0+7]));

        // Reset during the third WAIT state.
        cfg_valid = vt[1].fvalid; cfg_pat = vt[1].fpat; cfg_flags = vt[1].flags; cfg_mute = 1'b0;
        q0 = n_st_q; m0 = n_map;
        @(posedge clk); #2 start = 1'b1; num_weight_rows = 4'd8;
        @(posedge clk); #2 start = 1'b0; num_weight_rows = '0;
        for (int k = 0; k < 100 && (n_st_q - q0) < 3; k++) tick();
        check("third query seen", 64'(n_st_q - q0), 64'(3));
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("mid-run reset outputs", 64'(all_outs()), 64'(0));
        check("maps before reset", 64'(n_map - m0), 64'(2));
        m0 = n_map;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (6) tick();
        check("no map after reset", 64'(n_map - m0), 64'(0));
        check("idle after reset", 64'(all_outs()), 64'(0));
        run_vec(0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fault_aware_weight_allocator.md
Name: fault_aware_weight_allocator

Overview:
Sequences the faulty-PE storage during weight loading, before each systolic pass. On start it loads the fault list into storage, then walks the weight rows in order. For each row it fetches the zero-weight flags, queries storage for a faulty physical row that can absorb that weight, and otherwise falls back to the next free healthy row (step 4). Every placement is written to the mapping table, and the block reports completion, allocation overflow and uncovered faults.

Parameters:
SYSTOLIC_SIZE, 8, array dimension; also the maximum number of weight rows
ADDR_WIDTH, $clog2(SYSTOLIC_SIZE), physical row / weight index width
CNT_WIDTH, $clog2(SYSTOLIC_SIZE+1), weight-row count width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request; ignored while busy
num_weight_rows  in  CNT_WIDTH  weight rows to place; sampled on accepted start
busy  out  1  allocation in progress
done  out  1  one-cycle pulse at completion or abort
alloc_error  out  1  held until next accepted start
faults_uncovered  out  1  held until next accepted start
st_wr_en  out  1  storage load strobe
st_weight_valid  out  1  storage query strobe
st_zero_weight_flags  out  SYSTOLIC_SIZE  flags for the current query
st_current_row_addr  out  ADDR_WIDTH  current weight index
st_match_success  in  1  storage result: faulty row assigned
st_match_failed  in  1  storage result: no faulty row fits
st_faulty_row_addr  in  ADDR_WIDTH  assigned faulty row
st_faulty_rows_mask  in  SYSTOLIC_SIZE  rows containing faults
st_all_faulty_matched  in  1  no unused fault entries remain
wt_rd_en  out  1  weight-flag buffer read
wt_rd_addr  out  ADDR_WIDTH  weight index to read
wt_rd_data  in  SYSTOLIC_SIZE  zero flags; valid the cycle after wt_rd_en
map_wr_en  out  1  mapping-table write pulse
map_weight_idx  out  ADDR_WIDTH  logical weight row
map_phys_row  out  ADDR_WIDTH  physical row assigned
map_is_faulty_row  out  1  1 = placed on a faulty row via storage match

Behaviour:
- Reset: all outputs 0; FSM in IDLE; used_rows=0; weight index=0.
- IDLE: on start with num_weight_rows>SYSTOLIC_SIZE, go to DONE with alloc_error=1; st_wr_en is not asserted. On any other start, latch the count, clear alloc_error, faults_uncovered and used_rows, and go to LOAD. busy=1 from the cycle after the accepted start through the done cycle.
- LOAD: st_wr_en=1 for exactly 1 cycle → LOADWAIT. LOADWAIT lasts 1 cycle so the storage mask and valid bits settle.
- After LOADWAIT: if count==0 go to DONE; otherwise go to FETCH with idx=0.
- FETCH: if st_all_faulty_matched=1, go to RESULT in fallback mode with no wt_rd_en. Otherwise drive wt_rd_en=1, wt_rd_addr=idx and go to QUERY.
- QUERY: st_weight_valid=1 for exactly 1 cycle, with st_zero_weight_flags=wt_rd_data and st_current_row_addr=idx → WAIT.
- WAIT: 1 cycle while storage registers its result → RESULT.
- RESULT: sample st_match_success / st_match_failed.
  - success: phys=st_faulty_row_addr, faulty flag=1.
  - failed or fallback mode: phys=lowest index r with ~st_faulty_rows_mask[r] & ~used_rows[r], faulty flag=0.
  - No such r: alloc_error=1, no map write, go to DONE.
  - Both result bits 0 in query mode: protocol error; alloc_error=1, go to DONE.
  - Otherwise set used_rows[phys] and register the map_* outputs. map_wr_en pulses for 1 cycle, in the cycle after RESULT.
  - Then go to FETCH with idx+1, or to DONE when idx==count-1.
- Latency: 4 cycles per weight in query mode, 2 in fallback mode.
- DONE: done=1 for 1 cycle. faults_uncovered=~st_all_faulty_matched, sampled in DONE. Last map_wr_en coincides with the DONE cycle. → IDLE; busy falls after DONE.
- Strobes: st_wr_en, st_weight_valid, wt_rd_en and map_wr_en never exceed 1 cycle and never overlap each other, except map_wr_en with FETCH.
- Reset asserted mid-operation: immediate return to the reset state; no further map writes.

Test Plan:
- Faults at row2 (pattern 0x01) and row5 (pattern 0x80); weight flags 0x01, 0x80, then 0x00 x6; count=8 → maps (0→2,f=1), (1→5,f=1), then weights 2..7 → 0,1,3,4,6,7 with f=0. Weights 2..7 issue no wt_rd_en. done=1, alloc_error=0, faults_uncovered=0; 8 map_wr_en pulses total.
- Fault at row3 (pattern 0x0F); all weight flags 0x00; count=8 → weights 0..6 map to 0,1,2,4,5,6,7 (f=0). Weight 7 exhausts healthy rows → alloc_error=1, done pulse, 7 map writes total.
- Fault at row1 (pattern 0x03); count=1, flags 0x00 → weight0→row0 (f=0); done, faults_uncovered=1, alloc_error=0.
- count=0 → exactly one st_wr_en, no wt_rd_en or map_wr_en, done 2 cycles after LOAD; count=9 → done with alloc_error=1 and no st_wr_en.
- start re-pulsed during busy → ignored, results identical to the first scenario.
- rst_n low during the 3rd WAIT → all outputs 0 immediately, no map_wr_en afterwards; a new start completes normally.
